// File: rtl/cpu_pkg.sv
// Shared widths, arbiter FSM states and the pending-queue entry record
// used by the register-file write-port arbiter.
package cpu_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    DRAIN
  } arb_state_e;

  typedef struct packed {
    logic              live;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } pend_entry_t;

endpackage

// File: rtl/wb_pend_fifo.sv
// Circular buffer of pending MDU results with per-entry live bits and a
// kill-by-address port that retires entries overwritten by the pipeline.
module wb_pend_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  pend_entry_t              push_entry_i,
  input  logic                     pop_i,
  input  logic                     kill_i,
  input  logic [REG_W-1:0]         kill_rd_i,
  output pend_entry_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0]  live_q;
  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [AW-1:0]     wr_idx, rd_idx;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = '{live: live_q[rd_idx], rd: rd_q[rd_idx], data: data_q[rd_idx]};

  // Live bits are cleared on pop, so a stale slot can never match a kill.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      live_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_i && live_q[i] && (rd_q[i] == kill_rd_i)) live_q[i] <= 1'b0;
      end
      if (pop_i) begin
        live_q[rd_idx] <= 1'b0;
        rd_ptr_q       <= rd_ptr_q + (AW+1)'(1);
      end
      if (push_i) begin
        live_q[wr_idx] <= push_entry_i.live;
        wr_ptr_q       <= wr_ptr_q + (AW+1)'(1);
      end
    end
  end

  // NOTE: payload storage has no reset; only the live bits and pointers
  // define validity, so resetting the data array would just cost flops.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wr_idx]   <= push_entry_i.rd;
      data_q[wr_idx] <= push_entry_i.data;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the MEM/WB stage and queued
// MDU results, forcing a pipeline stall when a queued result starves.
module wb_port_arbiter #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_W      = cpu_pkg::REG_W,
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wb_valid,
  input  logic                    wb_memtoreg,
  input  logic [REG_W-1:0]        wb_rd,
  input  logic [DATA_W-1:0]       wb_alu,
  input  logic [DATA_W-1:0]       wb_mem,
  input  logic                    mdu_valid,
  input  logic [REG_W-1:0]        mdu_rd,
  input  logic [DATA_W-1:0]       mdu_data,
  output logic                    mdu_ready,
  output logic                    stall_req,
  output logic                    rf_we,
  output logic [REG_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]       rf_wdata,
  output logic [$clog2(QDEPTH):0] q_count
);

  import cpu_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  pend_entry_t       head;
  logic [CW-1:0]     count, cnt_nxt;
  logic              enq, deq, wb_take, kill;

  assign mdu_ready = (count != CW'(QDEPTH));
  assign stall_req = (state_q == DRAIN);
  assign enq       = mdu_valid && mdu_ready;
  assign kill      = wb_take && wb_valid;

  wb_pend_fifo #(
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (enq),
    .push_entry_i ('{live: 1'b1, rd: mdu_rd, data: mdu_data}),
    .pop_i        (deq),
    .kill_i       (kill),
    .kill_rd_i    (wb_rd),
    .head_o       (head),
    .count_o      (count)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    deq        = 1'b0;
    wb_take    = 1'b0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;

    unique case (state_q)
      IDLE:    wb_take = 1'b1;
      PEND:    if (wb_valid) wb_take = 1'b1; else deq = 1'b1;
      DRAIN:   deq = 1'b1;
      default: wb_take = 1'b1;
    endcase

    if (deq) begin
      rf_we_d    = head.live && (head.rd != '0);
      rf_waddr_d = head.rd;
      rf_wdata_d = head.data;
      starve_d   = '0;
    end else if (wb_take) begin
      rf_we_d    = wb_valid && (wb_rd != '0);
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_memtoreg ? wb_mem : wb_alu;
      if (state_q == PEND) starve_d = starve_q + SW'(1);
    end

    cnt_nxt = count + CW'(enq) - CW'(deq);

    // Transitions look at post-update occupancy and starvation.
    if (state_q == IDLE) begin
      if (enq) state_d = PEND;
    end else if (cnt_nxt == '0) begin
      state_d = IDLE;
    end else if ((cnt_nxt == CW'(QDEPTH)) || (starve_d >= SW'(STARVE_MAX))) begin
      state_d = DRAIN;
    end else begin
      state_d = PEND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = count;

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the register-file write port between the pipeline write-back stage (the MEM/WB register outputs) and the multi-cycle multiply/divide unit (MDU). MDU results land in a small pending queue. They are written in idle write-back slots. If a result waits too long, or the queue fills, the block requests a pipeline stall so the queue can drain. The block sits between the MEM/WB register, the MDU result bus and the register file write port. It also drives the hazard unit's stall input.

## Interface
Parameters:
- DATA_W, 32, data width
- REG_W, 5, register address width
- QDEPTH, 2, pending-queue entries (power of two, ≥2)
- STARVE_MAX, 4, cycles a queued head may wait before a stall is forced

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wb_valid  in  1  pipeline write request (RegWrite bit of the MEM/WB WB field)
- wb_memtoreg  in  1  1 = write wb_mem, 0 = write wb_alu
- wb_rd  in  REG_W  pipeline destination register
- wb_alu  in  DATA_W  ALU result from MEM/WB
- wb_mem  in  DATA_W  memory read data from MEM/WB
- mdu_valid  in  1  MDU result strobe
- mdu_rd  in  REG_W  MDU destination register
- mdu_data  in  DATA_W  MDU result
- mdu_ready  out  1  queue can accept; high when count < QDEPTH
- stall_req  out  1  freeze request to the hazard unit (combinational from state)
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  REG_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- q_count  out  clog2(QDEPTH)+1  number of queued entries

## Operation
- FIFO of QDEPTH entries {live, rd, data}.
  - Enqueue: mdu_valid && mdu_ready.
  - mdu_valid while mdu_ready=0 is a protocol error. The MDU must hold its result.
- Arbitration FSM states:
  - IDLE: queue empty. The pipeline always wins.
  - PEND: queue non-empty. The pipeline wins when wb_valid=1. Otherwise the queue head is dequeued and written. starve_cnt increments each cycle the head is not dequeued and clears on every dequeue.
  - DRAIN: stall_req=1. The queue head wins unconditionally. The pipeline request is not consumed; the hazard unit holds MEM/WB, so the same request is re-presented.
- Transitions:
  - IDLE→PEND on enqueue.
  - PEND→DRAIN when starve_cnt reaches STARVE_MAX, or when count == QDEPTH.
  - DRAIN→PEND after one dequeue, if the queue is still non-empty and not full; DRAIN→IDLE if the dequeue leaves it empty.
  - PEND→IDLE when the last entry is dequeued with no same-cycle enqueue.
- Write-after-write kill: when the pipeline wins with wb_valid=1 and wb_rd matches a queued live entry's rd, that entry's live bit clears (the younger pipeline value wins).
  - A dead entry is still dequeued in order but produces rf_we=0.
  - An entry enqueued in the same cycle is not killed.
- Register 0: any write with address 0 produces rf_we=0. The slot is still consumed.
- Simultaneous enqueue and dequeue: allowed; count is unchanged. An enqueue into an empty queue is not dequeued until the next cycle.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, q_count=0, stall_req=0, mdu_ready=1, FSM=IDLE, starve_cnt=0, all live bits 0.
- Reset asserted mid-operation discards all queued entries immediately. Outputs go to reset values asynchronously.
- Latency:
  - Pipeline request to register-file write: 1 cycle.
  - MDU strobe to earliest write: 2 cycles (enqueue, then dequeue).
- stall_req and mdu_ready are combinational from registered state only, with no input-to-output paths.
- Worst case, a queued result is written within STARVE_MAX+QDEPTH cycles of enqueue.

## Structure
- Shared package (cpu_pkg): REG_W, DATA_W, the FSM state enum {IDLE, PEND, DRAIN}, and the queue entry record type.
- One sub-module: wb_pend_fifo. It is a parameterised circular buffer with head/tail pointers one bit wider than the index, a per-entry live bit, and a kill-by-address port.
- The top level holds the FSM, starve counter, kill compare and registered write port.

## Test plan
- Reset: drive rst_n=0 mid-traffic → all outputs reach reset values with no clock edge; q_count=0.
- Idle slot: mdu_valid with rd=8, data=0x0000_00AB, wb_valid=0 thereafter → rf_we=1, waddr=8, wdata=0xAB two cycles after the strobe.
- Starvation: one MDU entry (rd=3), wb_valid=1 continuously with rd=9 → stall_req=1 on cycle STARVE_MAX (4) after enqueue. The following write is waddr=3. stall_req then drops and the held pipeline write (rd=9) completes next.
- Full queue: two MDU results back-to-back under continuous wb_valid → mdu_ready=0, q_count=2, stall_req=1. Entries drain in enqueue order.
- Kill: queue rd=5 data=0x11, then a pipeline write rd=5 data=0x22 with wb_memtoreg=1 (the data is carried on wb_mem) → register 5 is written with 0x22 only; the dequeue of the dead entry shows rf_we=0.
- Register 0: pipeline write with rd=0, and MDU write with rd=0 → rf_we stays 0 for both; q_count returns to 0.
